// File: rtl/thermostat_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : thermostat_pkg
//  Brief    : State encoding and default timing constants shared by the
//             thermostat sequencer, its interface and its counters.
//  Revision : 1.0 - initial release
// ============================================================================
package thermostat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        HEATING = 2'b01,
        COOLING = 2'b10,
        HOLDOFF = 2'b11
    } state_t;

    localparam int DEF_MIN_ON   = 4;
    localparam int DEF_MIN_OFF  = 3;
    localparam int DEF_FAN_TAIL = 2;
    localparam int DEF_CNT_W    = 8;

endpackage : thermostat_pkg
`default_nettype wire

// File: rtl/thermostat_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : thermostat_sequencer_if
//  Brief    : Comparator inputs, timebase and output drives of the sequencer.
//             The master side feeds demands and reads drives; the slave side
//             is the sequencer itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface thermostat_sequencer_if;

    logic       tick;
    logic       enable;
    logic       mode;
    logic       too_cold;
    logic       too_hot;
    logic       fan_on;
    logic       heater;
    logic       aircon;
    logic       fan;
    logic [1:0] state;
    logic       blocked;

    modport master (
        output tick, enable, mode, too_cold, too_hot, fan_on,
        input  heater, aircon, fan, state, blocked
    );

    modport slave (
        input  tick, enable, mode, too_cold, too_hot, fan_on,
        output heater, aircon, fan, state, blocked
    );

endinterface : thermostat_sequencer_if
`default_nettype wire

// File: rtl/thermostat_sequencer_tick_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tick_counter
//  Brief    : Tick-enabled up/down counter with clear, load, saturation at
//             LIMIT when counting up and at zero when counting down.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 4
) (
    input  wire logic             clk,
    input  wire logic             areset_n,
    input  wire logic             i_clr,
    input  wire logic             i_load,
    input  wire logic [CNT_W-1:0] i_load_val,
    input  wire logic             i_en,
    input  wire logic             i_up,
    output logic      [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Clear beats load beats counting; counting holds at its end stop.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (i_up && (r_cnt != c_limit)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!i_up && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule : tick_counter
`default_nettype wire

// File: rtl/thermostat_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : thermostat_sequencer
//  Brief    : Heater / aircon / fan sequencer with minimum run time, minimum
//             off time, fan post-run tail and safety force-off.
//  Revision : 1.0 - initial release
// ============================================================================
module thermostat_sequencer
    import thermostat_pkg::*;
#(
    parameter int MIN_ON   = DEF_MIN_ON,
    parameter int MIN_OFF  = DEF_MIN_OFF,
    parameter int FAN_TAIL = DEF_FAN_TAIL,
    parameter int CNT_W    = DEF_CNT_W
) (
    input wire logic              clk,
    input wire logic              areset_n,
    thermostat_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] c_min_on   = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] c_min_off  = CNT_W'(MIN_OFF);
    localparam logic [CNT_W-1:0] c_fan_tail = CNT_W'(FAN_TAIL);

    generate
        if (MIN_ON == 0 || MIN_OFF == 0) begin : g_bad_timing
            $error("thermostat_sequencer: MIN_ON and MIN_OFF must be at least 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_exit_run;
    logic             w_heat_dem;
    logic             w_cool_dem;
    logic             w_running;
    logic             w_tail_nz_nxt;
    logic [CNT_W-1:0] r_run_cnt;
    logic [CNT_W-1:0] r_off_cnt;
    logic [CNT_W-1:0] r_tail_cnt;
    logic             r_heater;
    logic             r_aircon;
    logic             r_fan;
    logic             r_blocked;

    assign w_heat_dem = bus.enable &  bus.mode & bus.too_cold;
    assign w_cool_dem = bus.enable & ~bus.mode & bus.too_hot;
    assign w_running  = (r_state == HEATING) || (r_state == COOLING);

    // Run time: held at zero in IDLE so every run starts counting from 0.
    tick_counter #(.CNT_W(CNT_W), .LIMIT(MIN_ON)) u_run_cnt (
        .clk        (clk),
        .areset_n   (areset_n),
        .i_clr      (r_state == IDLE),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (bus.tick && w_running),
        .i_up       (1'b1),
        .o_cnt      (r_run_cnt)
    );

    // Off time: restarted on every exit from a run, counts only in HOLDOFF.
    tick_counter #(.CNT_W(CNT_W), .LIMIT(MIN_OFF)) u_off_cnt (
        .clk        (clk),
        .areset_n   (areset_n),
        .i_clr      (w_exit_run),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (bus.tick && (r_state == HOLDOFF)),
        .i_up       (1'b1),
        .o_cnt      (r_off_cnt)
    );

    // Fan tail: reloaded on run exit, drains on tick in any state.
    tick_counter #(.CNT_W(CNT_W), .LIMIT(FAN_TAIL)) u_tail_cnt (
        .clk        (clk),
        .areset_n   (areset_n),
        .i_clr      (1'b0),
        .i_load     (w_exit_run),
        .i_load_val (c_fan_tail),
        .i_en       (bus.tick),
        .i_up       (1'b0),
        .o_cnt      (r_tail_cnt)
    );

    // Whether the tail counter will be nonzero after this edge.
    assign w_tail_nz_nxt = w_exit_run ? (c_fan_tail != '0)
                         : ((r_tail_cnt != '0) && !(bus.tick && (r_tail_cnt == CNT_W'(1))));

    // State register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= HOLDOFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a run ends on force-off or once demand is gone and
    // the minimum run time has elapsed.
    always_comb begin
        w_state_nxt = r_state;
        w_exit_run  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_heat_dem) begin
                    w_state_nxt = HEATING;
                end else if (w_cool_dem) begin
                    w_state_nxt = COOLING;
                end
            end
            HEATING: begin
                if (!bus.enable || (!w_heat_dem && (r_run_cnt == c_min_on))) begin
                    w_state_nxt = HOLDOFF;
                    w_exit_run  = 1'b1;
                end
            end
            COOLING: begin
                if (!bus.enable || (!w_cool_dem && (r_run_cnt == c_min_on))) begin
                    w_state_nxt = HOLDOFF;
                    w_exit_run  = 1'b1;
                end
            end
            HOLDOFF: begin
                if (r_off_cnt == c_min_off) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = HOLDOFF;
            end
        endcase
    end

    // Output drives registered from next-state values.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_heater  <= 1'b0;
            r_aircon  <= 1'b0;
            r_fan     <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_heater  <= (w_state_nxt == HEATING);
            r_aircon  <= (w_state_nxt == COOLING);
            r_fan     <= (w_state_nxt == HEATING) || (w_state_nxt == COOLING)
                         || bus.fan_on || w_tail_nz_nxt;
            r_blocked <= (w_state_nxt == HOLDOFF) && (w_heat_dem || w_cool_dem);
        end
    end

    assign bus.heater  = r_heater;
    assign bus.aircon  = r_aircon;
    assign bus.fan     = r_fan;
    assign bus.state   = r_state;
    assign bus.blocked = r_blocked;

endmodule : thermostat_sequencer
`default_nettype wire
